// File: rtl/stage3_flit_arbiter.sv
// Stage-3 output unit: buffers system and normal flits in two FIFOs and merges
// them onto one valid/ready channel. System traffic has priority; a bounded
// starvation counter forces a normal grant after STARVE_LIMIT system grants.

package types;
  // Flit payload carried through the router pipeline
  typedef struct packed {
    logic [7:0]  dest;
    logic [23:0] payload;
  } flit_t;
endpackage

module stage3_flit_arbiter #(
  parameter int unsigned SYS_DEPTH    = 4,
  parameter int unsigned NORM_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                            nocclk,
  input  logic                            rst_n,
  input  logic                            in_sys_flit_valid,
  input  types::flit_t                    in_sys_flit,
  output logic                            out_sys_ready,
  input  logic                            in_normal_flit_valid,
  input  types::flit_t                    in_normal_flit,
  output logic                            out_normal_ready,
  output logic                            out_flit_valid,
  output types::flit_t                    out_flit,
  input  logic                            in_flit_ready,
  output logic [$clog2(SYS_DEPTH+1)-1:0]  out_sys_count,
  output logic [$clog2(NORM_DEPTH+1)-1:0] out_normal_count,
  output logic                            out_starve_event
);

  localparam int unsigned SCW   = $clog2(SYS_DEPTH + 1);
  localparam int unsigned NCW   = $clog2(NORM_DEPTH + 1);
  localparam int unsigned SPW   = $clog2(SYS_DEPTH);
  localparam int unsigned NPW   = $clog2(NORM_DEPTH);
  localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {
    GNT_SYS  = 1'b0,
    GNT_NORM = 1'b1
  } grant_e;

  // Storage (no reset: contents are don't-care until written)
  types::flit_t sys_mem  [SYS_DEPTH];
  types::flit_t norm_mem [NORM_DEPTH];

  // Registered state
  logic [SPW-1:0] sys_wr_q, sys_rd_q, sys_wr_d, sys_rd_d;
  logic [NPW-1:0] norm_wr_q, norm_rd_q, norm_wr_d, norm_rd_d;
  logic [SCW-1:0] sys_cnt_q, sys_cnt_d;
  logic [NCW-1:0] norm_cnt_q, norm_cnt_d;
  logic           sys_rdy_q, sys_rdy_d;
  logic           norm_rdy_q, norm_rdy_d;
  grant_e         grant_q, grant_d;
  logic           lock_q, lock_d;
  logic [7:0]     starve_q, starve_d;
  logic           event_q, event_d;

  // Combinational decode
  grant_e sel_c;
  logic   vld_c;
  logic   sys_nempty_c, norm_nempty_c;
  logic   sys_push_c, norm_push_c;
  logic   pop_c, sys_pop_c, norm_pop_c;

  assign sys_nempty_c  = (sys_cnt_q != '0);
  assign norm_nempty_c = (norm_cnt_q != '0);
  assign sys_push_c    = in_sys_flit_valid & sys_rdy_q;
  assign norm_push_c   = in_normal_flit_valid & norm_rdy_q;

  // Grant selection from registered state only; a lock freezes the choice
  always_comb begin
    sel_c = GNT_SYS;
    vld_c = 1'b0;
    if (lock_q) begin
      sel_c = grant_q;
      vld_c = 1'b1;
    end else if ((starve_q == LIMIT) && norm_nempty_c) begin
      sel_c = GNT_NORM;
      vld_c = 1'b1;
    end else if (sys_nempty_c) begin
      sel_c = GNT_SYS;
      vld_c = 1'b1;
    end else if (norm_nempty_c) begin
      sel_c = GNT_NORM;
      vld_c = 1'b1;
    end
  end

  assign pop_c      = vld_c & in_flit_ready;
  assign sys_pop_c  = pop_c & (sel_c == GNT_SYS);
  assign norm_pop_c = pop_c & (sel_c == GNT_NORM);

  // Output mux: head of the granted FIFO, zero when nothing is presented
  always_comb begin
    out_flit = '0;
    if (vld_c) begin
      out_flit = (sel_c == GNT_NORM) ? norm_mem[norm_rd_q] : sys_mem[sys_rd_q];
    end
  end

  assign out_flit_valid   = vld_c;
  assign out_sys_ready    = sys_rdy_q;
  assign out_normal_ready = norm_rdy_q;
  assign out_sys_count    = sys_cnt_q;
  assign out_normal_count = norm_cnt_q;
  assign out_starve_event = event_q;

  // Next-state for pointers, counts, ready, grant/lock and starvation tracking
  always_comb begin
    sys_wr_d   = sys_wr_q;
    sys_rd_d   = sys_rd_q;
    norm_wr_d  = norm_wr_q;
    norm_rd_d  = norm_rd_q;
    sys_cnt_d  = sys_cnt_q;
    norm_cnt_d = norm_cnt_q;
    grant_d    = grant_q;
    lock_d     = lock_q;
    starve_d   = starve_q;
    event_d    = 1'b0;

    if (sys_push_c) sys_wr_d = sys_wr_q + SPW'(1);
    if (sys_pop_c)  sys_rd_d = sys_rd_q + SPW'(1);
    if (norm_push_c) norm_wr_d = norm_wr_q + NPW'(1);
    if (norm_pop_c)  norm_rd_d = norm_rd_q + NPW'(1);

    if (sys_push_c && !sys_pop_c)      sys_cnt_d = sys_cnt_q + SCW'(1);
    else if (sys_pop_c && !sys_push_c) sys_cnt_d = sys_cnt_q - SCW'(1);
    if (norm_push_c && !norm_pop_c)      norm_cnt_d = norm_cnt_q + NCW'(1);
    else if (norm_pop_c && !norm_push_c) norm_cnt_d = norm_cnt_q - NCW'(1);

    sys_rdy_d  = (sys_cnt_d < SCW'(SYS_DEPTH));
    norm_rdy_d = (norm_cnt_d < NCW'(NORM_DEPTH));

    // Lock holds a presented flit stable until downstream takes it
    if (pop_c) begin
      lock_d = 1'b0;
    end else if (vld_c && !in_flit_ready) begin
      lock_d = 1'b1;
    end
    if (vld_c) grant_d = sel_c;

    // Starvation counter: reset by normal service or an idle normal queue
    if (norm_pop_c) begin
      starve_d = '0;
    end else if (!norm_nempty_c && !norm_push_c) begin
      starve_d = '0;
    end else if (sys_pop_c && norm_nempty_c && (starve_q < LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end

    event_d = norm_pop_c && (starve_q == LIMIT);
  end

  // Control/state registers with asynchronous reset
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      sys_wr_q   <= '0;
      sys_rd_q   <= '0;
      norm_wr_q  <= '0;
      norm_rd_q  <= '0;
      sys_cnt_q  <= '0;
      norm_cnt_q <= '0;
      sys_rdy_q  <= 1'b1;
      norm_rdy_q <= 1'b1;
      grant_q    <= GNT_SYS;
      lock_q     <= 1'b0;
      starve_q   <= '0;
      event_q    <= 1'b0;
    end else begin
      sys_wr_q   <= sys_wr_d;
      sys_rd_q   <= sys_rd_d;
      norm_wr_q  <= norm_wr_d;
      norm_rd_q  <= norm_rd_d;
      sys_cnt_q  <= sys_cnt_d;
      norm_cnt_q <= norm_cnt_d;
      sys_rdy_q  <= sys_rdy_d;
      norm_rdy_q <= norm_rdy_d;
      grant_q    <= grant_d;
      lock_q     <= lock_d;
      starve_q   <= starve_d;
      event_q    <= event_d;
    end
  end

  // FIFO storage writes
  always_ff @(posedge nocclk) begin
    if (sys_push_c)  sys_mem[sys_wr_q]   <= in_sys_flit;
    if (norm_push_c) norm_mem[norm_wr_q] <= in_normal_flit;
  end

endmodule

// File: tb/tb_stage3_flit_arbiter.sv
// Self-checking bench for stage3_flit_arbiter: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_stage3_flit_arbiter;
  import types::*;

  localparam int SD  = 4;
  localparam int ND  = 4;
  localparam int LIM = 2;

  logic  nocclk = 1'b0;
  logic  rst_n  = 1'b1;
  logic  in_sys_flit_valid = 1'b0;
  flit_t in_sys_flit = '0;
  logic  out_sys_ready;
  logic  in_normal_flit_valid = 1'b0;
  flit_t in_normal_flit = '0;
  logic  out_normal_ready;
  logic  out_flit_valid;
  flit_t out_flit;
  logic  in_flit_ready = 1'b0;
  logic [$clog2(SD+1)-1:0] out_sys_count;
  logic [$clog2(ND+1)-1:0] out_normal_count;
  logic  out_starve_event;

  always #5 nocclk = ~nocclk;

  stage3_flit_arbiter #(
    .SYS_DEPTH   (SD),
    .NORM_DEPTH  (ND),
    .STARVE_LIMIT(LIM)
  ) dut (
    .nocclk              (nocclk),
    .rst_n               (rst_n),
    .in_sys_flit_valid   (in_sys_flit_valid),
    .in_sys_flit         (in_sys_flit),
    .out_sys_ready       (out_sys_ready),
    .in_normal_flit_valid(in_normal_flit_valid),
    .in_normal_flit      (in_normal_flit),
    .out_normal_ready    (out_normal_ready),
    .out_flit_valid      (out_flit_valid),
    .out_flit            (out_flit),
    .in_flit_ready       (in_flit_ready),
    .out_sys_count       (out_sys_count),
    .out_normal_count    (out_normal_count),
    .out_starve_event    (out_starve_event)
  );

  int total  = 0;
  int passed = 0;

  // Reference model state
  flit_t sysq[$];
  flit_t normq[$];
  bit    m_locked = 0;
  bit    m_lock_norm = 0;
  int    m_starve = 0;
  bit    m_ev = 0;

  // Observation logs for directed checks
  bit    chk_en = 0;
  int    cyc = 0;
  flit_t popq[$];
  int    pop_cyc[$];
  int    ev_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic flit_t mk(input int unsigned x);
    return flit_t'(32'(x));
  endfunction

  // Which flit the rules say must be presented this cycle
  function automatic void m_sel(output bit v, output bit n, output bit ovr);
    v = 0; n = 0;
    if (m_locked) begin
      v = 1; n = m_lock_norm;
    end else if (m_starve == LIM && normq.size() > 0) begin
      v = 1; n = 1;
    end else if (sysq.size() > 0) begin
      v = 1; n = 0;
    end else if (normq.size() > 0) begin
      v = 1; n = 1;
    end
    ovr = v && n && (m_starve == LIM);
  endfunction

  // Model advance at each active edge
  always @(posedge nocclk or negedge rst_n) begin
    bit v, n, o, pop, ps, pn;
    if (!rst_n) begin
      sysq.delete(); normq.delete();
      m_locked = 0; m_lock_norm = 0; m_starve = 0; m_ev = 0;
    end else begin
      m_sel(v, n, o);
      pop = v && in_flit_ready;
      ps  = in_sys_flit_valid && (sysq.size() < SD);
      pn  = in_normal_flit_valid && (normq.size() < ND);
      m_ev = pop && n && o;
      if (pop && n) m_starve = 0;
      else if (normq.size() == 0 && !pn) m_starve = 0;
      else if (pop && !n && normq.size() > 0 && m_starve < LIM) m_starve++;
      m_locked = v && !in_flit_ready;
      m_lock_norm = n;
      if (pop) begin
        if (n) void'(normq.pop_front());
        else   void'(sysq.pop_front());
      end
      if (ps) sysq.push_back(in_sys_flit);
      if (pn) normq.push_back(in_normal_flit);
    end
  end

  // Compare process: DUT vs model on every falling edge
  always @(negedge nocclk) begin
    bit v, n, o;
    flit_t ef;
    cyc++;
    if (chk_en) begin
      m_sel(v, n, o);
      ef = '0;
      if (v) ef = n ? normq[0] : sysq[0];
      chk("valid",        32'(out_flit_valid),   32'(v));
      chk("flit",         32'(out_flit),         32'(ef));
      chk("sys_count",    32'(out_sys_count),    32'(sysq.size()));
      chk("normal_count", 32'(out_normal_count), 32'(normq.size()));
      chk("sys_ready",    32'(out_sys_ready),    32'(sysq.size() < SD));
      chk("normal_ready", 32'(out_normal_ready), 32'(normq.size() < ND));
      chk("starve_event", 32'(out_starve_event), 32'(m_ev));
      if (out_flit_valid && in_flit_ready) begin
        popq.push_back(out_flit);
        pop_cyc.push_back(cyc);
      end
      if (out_starve_event) ev_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic clear_logs();
    popq.delete(); pop_cyc.delete(); ev_cyc.delete();
  endtask

  // Run with ready high until the model is empty, bounded
  task automatic drain(input int maxc);
    int n = 0;
    in_flit_ready = 1'b1;
    while ((sysq.size() + normq.size()) > 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(sysq.size() + normq.size()), 32'd0);
  endtask

  task automatic chk_order(input string name, input int unsigned exp[$]);
    chk({name, "_len"}, 32'(popq.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < popq.size()) chk(name, 32'(popq[i]), 32'(exp[i]));
      else chk(name, 32'hdead_beef, 32'(exp[i]));
    end
  endtask

  initial begin
    int idx;

    // Reset
    #2 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) tick();
    chk("rst_valid",     32'(out_flit_valid),   32'd0);
    chk("rst_flit",      32'(out_flit),         32'd0);
    chk("rst_sys_rdy",   32'(out_sys_ready),    32'd1);
    chk("rst_norm_rdy",  32'(out_normal_ready), 32'd1);
    chk("rst_sys_cnt",   32'(out_sys_count),    32'd0);
    chk("rst_norm_cnt",  32'(out_normal_count), 32'd0);
    chk("rst_event",     32'(out_starve_event), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full boundary on the system FIFO
    clear_logs();
    in_flit_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_sys_flit_valid = 1'b1;
      in_sys_flit = mk(i);
      tick();
    end
    chk("full_count", 32'(out_sys_count), 32'd4);
    chk("full_ready", 32'(out_sys_ready), 32'd0);
    in_sys_flit = mk(5);
    tick(); tick();
    chk("full_hold_count", 32'(out_sys_count), 32'd4);
    in_flit_ready = 1'b1;
    tick();
    chk("first_pop_count", 32'(out_sys_count), 32'd3);
    chk("first_pop_ready", 32'(out_sys_ready), 32'd1);
    tick();
    in_sys_flit_valid = 1'b0;
    chk("push5_count", 32'(out_sys_count), 32'd3);
    drain(20);
    chk_order("full_order", '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5});

    // System priority over preloaded normal flits
    clear_logs();
    in_flit_ready = 1'b0;
    in_normal_flit_valid = 1'b1; in_normal_flit = mk(32'hA0);
    in_sys_flit_valid = 1'b1;    in_sys_flit = mk(32'h51);
    tick();
    in_normal_flit = mk(32'hB0);
    in_sys_flit = mk(32'h52);
    tick();
    in_normal_flit_valid = 1'b0; in_sys_flit_valid = 1'b0;
    drain(20);
    chk_order("prio_order", '{32'h51, 32'h52, 32'hA0, 32'hB0});
    chk("prio_consecutive", 32'(pop_cyc.size() == 4 ? pop_cyc[3] - pop_cyc[0] : 0), 32'd3);

    // Starvation override with a continuously fed system FIFO
    clear_logs();
    in_flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sys_flit_valid = 1'b1;
      in_sys_flit = mk(32'h100 + i);
      in_normal_flit_valid = (i == 2);
      in_normal_flit = mk(32'hEE);
      tick();
    end
    in_sys_flit_valid = 1'b0; in_normal_flit_valid = 1'b0;
    drain(20);
    tick();
    chk_order("starve_order", '{32'h100, 32'h101, 32'h102, 32'h103, 32'hEE,
                                32'h104, 32'h105, 32'h106, 32'h107});
    chk("starve_ev_count", 32'(ev_cyc.size()), 32'd1);
    idx = -1;
    foreach (popq[i]) if (32'(popq[i]) == 32'hEE) idx = i;
    if (idx >= 0 && ev_cyc.size() > 0) chk("starve_ev_cycle", 32'(ev_cyc[0]), 32'(pop_cyc[idx] + 1));
    else chk("starve_ev_cycle", 32'hffff_ffff, 32'd0);

    // Stall stability: presented normal flit holds while a system flit arrives
    clear_logs();
    in_flit_ready = 1'b0;
    in_normal_flit_valid = 1'b1; in_normal_flit = mk(32'h77);
    tick();
    in_normal_flit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sys_flit_valid = (i == 1);
      in_sys_flit = mk(32'h55);
      chk("stall_flit",  32'(out_flit),       32'h77);
      chk("stall_valid", 32'(out_flit_valid), 32'd1);
      tick();
    end
    in_sys_flit_valid = 1'b0;
    chk("stall_flit_end", 32'(out_flit), 32'h77);
    drain(20);
    chk_order("stall_order", '{32'h77, 32'h55});

    // Simultaneous push and pop on the normal FIFO, wrapping pointers
    clear_logs();
    in_flit_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_normal_flit_valid = 1'b1;
      in_normal_flit = mk(32'h200 + i);
      tick();
    end
    chk("simul_pre_count", 32'(out_normal_count), 32'd2);
    in_flit_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_normal_flit = mk(32'h202 + i);
      tick();
      chk("simul_count", 32'(out_normal_count), 32'd2);
    end
    in_normal_flit_valid = 1'b0;
    drain(20);
    chk_order("simul_order", '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205,
                               32'h206, 32'h207, 32'h208, 32'h209, 32'h20A, 32'h20B});

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_sys_flit_valid    = ($urandom_range(0, 9) < 4);
      in_normal_flit_valid = ($urandom_range(0, 9) < 4);
      in_sys_flit          = mk($urandom);
      in_normal_flit       = mk($urandom);
      in_flit_ready        = ($urandom_range(0, 9) < (((i / 400) % 2) ? 3 : 8));
      tick();
    end
    in_sys_flit_valid = 1'b0; in_normal_flit_valid = 1'b0;
    drain(50);

    // Asynchronous reset mid-burst with three flits buffered
    in_flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sys_flit_valid = 1'b1;
      in_sys_flit = mk(32'h300 + i);
      tick();
    end
    in_sys_flit_valid = 1'b0;
    chk("burst_count", 32'(out_sys_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(out_flit_valid),   32'd0);
    chk("arst_flit",     32'(out_flit),         32'd0);
    chk("arst_sys_rdy",  32'(out_sys_ready),    32'd1);
    chk("arst_norm_rdy", 32'(out_normal_ready), 32'd1);
    chk("arst_sys_cnt",  32'(out_sys_count),    32'd0);
    chk("arst_norm_cnt", 32'(out_normal_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_valid", 32'(out_flit_valid), 32'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global run bound
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time bound, %0d/%0d passed so far", passed, total);
    $fatal(1);
  end

endmodule
